// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: blink, chase, breathe and solid modes with a per-channel DIP mask.
// Define DIP_SYNC_EN to add a 2-flop DIP synchroniser and an 8-tick debouncer in front of the mask.
module led_pattern_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [CHANNELS-1:0] dip,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_W   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
  localparam logic [PWM_BITS-1:0] DMAX = '1;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e                 mode_q, mode_d;
  dir_e                  dir_q, dir_d;
  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  phase_q, phase_d;
  logic [CHANNELS-1:0]   pos_q, pos_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0]   led_q, led_d;
  logic [CHANNELS-1:0]   lit;
  logic [CHANNELS-1:0]   dip_m;
  logic                  tick;
  logic                  sec;
  logic                  restart;

  assign tick    = (pre_cnt_q == PRE_W'(TICK_DIV - 1));
  assign sec     = tick && (tick_cnt_q == TICK_W'(TICK_HZ - 1));
  assign restart = (mode != mode_q);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      mode_q     <= MODE_BLINK;
      dir_q      <= DIR_UP;
      pre_cnt_q  <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b0;
      pos_q      <= CHANNELS'(1);
      duty_q     <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '1;
    end else begin
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
    end
  end

  // A mode change restarts all timing and pattern state, overriding any tick or sec this cycle.
  always_comb begin
    mode_d     = mode_e'(mode);
    dir_d      = dir_q;
    pre_cnt_d  = pre_cnt_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    if (restart) begin
      dir_d      = DIR_UP;
      pre_cnt_d  = '0;
      tick_cnt_d = '0;
      phase_d    = 1'b0;
      pos_d      = CHANNELS'(1);
      duty_d     = '0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) begin
        tick_cnt_d = sec ? '0 : tick_cnt_q + 1'b1;
      end
      unique case (mode_q)
        MODE_BLINK: begin
          if (sec) phase_d = ~phase_q;
        end
        MODE_CHASE: begin
          if (sec) pos_d = (pos_q << 1) | (pos_q >> (CHANNELS - 1));
        end
        MODE_BREATHE: begin
          if (tick) begin
            if (dir_q == DIR_UP) begin
              if (duty_q == DMAX) begin
                dir_d  = DIR_DOWN;
                duty_d = duty_q - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                dir_d  = DIR_UP;
                duty_d = duty_q + 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    lit = '0;
    unique case (mode_q)
      MODE_BLINK:   lit = {CHANNELS{phase_q}};
      MODE_CHASE:   lit = pos_q;
      MODE_BREATHE: lit = {CHANNELS{pwm_cnt_q < duty_q}};
      default:      lit = '1;
    endcase
    led_d = ~(lit & dip_m);
  end

  assign led = led_q;

`ifdef DIP_SYNC_EN
  logic [CHANNELS-1:0]      sync1_q, sync2_q;
  logic [CHANNELS-1:0]      last_q, last_d;
  logic [CHANNELS-1:0]      dip_m_q, dip_m_d;
  logic [CHANNELS-1:0][2:0] stable_q, stable_d;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      last_q   <= '0;
      dip_m_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= dip;
      sync2_q  <= sync1_q;
      last_q   <= last_d;
      dip_m_q  <= dip_m_d;
      stable_q <= stable_d;
    end
  end

  // The eighth consecutive tick without a change commits the synchronised value.
  always_comb begin
    last_d   = last_q;
    dip_m_d  = dip_m_q;
    stable_d = stable_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2_q[i] != last_q[i]) begin
        last_d[i]   = sync2_q[i];
        stable_d[i] = 3'd0;
      end else if (tick) begin
        if (stable_q[i] == 3'd7) begin
          dip_m_d[i] = last_q[i];
        end else begin
          stable_d[i] = stable_q[i] + 3'd1;
        end
      end
    end
  end

  assign dip_m = dip_m_q;
`else
  assign dip_m = dip;
`endif

endmodule
